// File: rtl/bomb_referee_if.sv
// Bundle between the bomb's top-level FSM side and the game referee.
//   fsm_state    : FSM current state (IDLE=0 .. SUCCESS=5)
//   module_en    : mask of puzzle modules present in this game
//   solved_pulse : 1-cycle per-module "solved" pulses
//   strike_pulse : 1-cycle per-module "wrong action" pulses
//   explode      : detonation request (level)
//   all_solved   : every enabled module solved (level)
//   seconds_left : remaining countdown seconds
//   strikes      : current strike count
//   solved_mask  : latched solved flags
//   tick         : 1-cycle pulse per countdown decrement
interface bomb_referee_if #(
    parameter int NUM_MODULES = 6
);
    logic [2:0]             fsm_state;
    logic [NUM_MODULES-1:0] module_en;
    logic [NUM_MODULES-1:0] solved_pulse;
    logic [NUM_MODULES-1:0] strike_pulse;
    logic                   explode;
    logic                   all_solved;
    logic [9:0]             seconds_left;
    logic [1:0]             strikes;
    logic [NUM_MODULES-1:0] solved_mask;
    logic                   tick;

    // master: the FSM / puzzle side that feeds the referee
    modport master (
        output fsm_state, module_en, solved_pulse, strike_pulse,
        input  explode, all_solved, seconds_left, strikes, solved_mask, tick
    );

    // slave: the referee itself
    modport slave (
        input  fsm_state, module_en, solved_pulse, strike_pulse,
        output explode, all_solved, seconds_left, strikes, solved_mask, tick
    );
endinterface

// File: rtl/bomb_referee.sv
// Game-rules controller beside the bomb FSM: countdown timer with a
// strike-accelerated prescaler, strike counter, and latched solved flags.
// Ports:
//   clk : system clock
//   rst : synchronous active-high reset
//   bus : bomb_referee_if.slave (FSM state + module pulses in, status out)
// All outputs are registered; input pulses show up one clk later.
module bomb_referee #(
    parameter int NUM_MODULES   = 6,
    parameter int TICK_DIV      = 50000000,
    parameter int START_SECONDS = 300,
    parameter int MAX_STRIKES   = 3
) (
    input logic           clk,
    input logic           rst,
    bomb_referee_if.slave bus
);
    localparam int             PW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW:0]    DIV      = (PW+1)'(TICK_DIV);
    localparam logic [9:0]     SEC0     = 10'(START_SECONDS);
    localparam logic [1:0]     SMAX     = 2'(MAX_STRIKES);
    localparam logic [2:0]     FS_IDLE  = 3'd0;
    localparam logic [2:0]     FS_ARMED = 3'd2;

    typedef enum logic [1:0] {WAIT, RUN, DONE_FAIL, DONE_WIN} state_t;

    state_t                 state;
    logic [PW-1:0]          presc;
    logic [NUM_MODULES-1:0] en_q;
    logic [NUM_MODULES-1:0] mask_q;
    logic [9:0]             sec_q;
    logic [1:0]             strikes_q;
    logic                   explode_q, win_q, tick_q;

    logic [PW:0]            limit;
    logic                   wrap, dec, timeout, strike_inc, boom, win;
    logic [PW-1:0]          presc_nxt;
    logic [1:0]             strikes_nxt;
    logic [NUM_MODULES-1:0] solve_new, strike_vec, mask_nxt;

    always_comb begin
        // Each strike halves the prescaler period. Using >= rather than ==
        // lets a shrinking limit force an immediate wrap.
        limit       = DIV >> strikes_q;
        wrap        = ({1'b0, presc} + (PW+1)'(1)) >= limit;
        presc_nxt   = wrap ? '0 : presc + PW'(1);
        dec         = wrap && (sec_q != 10'd0);
        timeout     = dec && (sec_q == 10'd1);

        solve_new   = bus.solved_pulse & en_q & ~mask_q;
        // A solve in the same cycle masks a strike from that module.
        strike_vec  = bus.strike_pulse & en_q & ~mask_q & ~bus.solved_pulse;
        strike_inc  = (|strike_vec) && (strikes_q != SMAX);
        strikes_nxt = strike_inc ? strikes_q + 2'd1 : strikes_q;
        mask_nxt    = mask_q | solve_new;

        boom        = timeout || (strike_inc && (strikes_nxt == SMAX));
        // explode beats a coincident final solve
        win         = ((mask_nxt & en_q) == en_q) && !boom;
    end

    always_ff @(posedge clk) begin
        if (rst || bus.fsm_state == FS_IDLE) begin
            state     <= WAIT;
            presc     <= '0;
            en_q      <= '0;
            mask_q    <= '0;
            sec_q     <= SEC0;
            strikes_q <= '0;
            explode_q <= 1'b0;
            win_q     <= 1'b0;
            tick_q    <= 1'b0;
        end else begin
            tick_q <= 1'b0;
            case (state)
                WAIT: begin
                    if (bus.fsm_state == FS_ARMED) begin
                        en_q  <= bus.module_en;
                        presc <= '0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    presc     <= presc_nxt;
                    tick_q    <= dec;
                    if (dec) sec_q <= sec_q - 10'd1;
                    strikes_q <= strikes_nxt;
                    mask_q    <= mask_nxt;
                    if (boom) begin
                        explode_q <= 1'b1;
                        state     <= DONE_FAIL;
                    end else if (win) begin
                        win_q <= 1'b1;
                        state <= DONE_WIN;
                    end
                end
                default: ; // DONE_*: everything frozen
            endcase
        end
    end

    assign bus.explode      = explode_q;
    assign bus.all_solved   = win_q;
    assign bus.seconds_left = sec_q;
    assign bus.strikes      = strikes_q;
    assign bus.solved_mask  = mask_q;
    assign bus.tick         = tick_q;
endmodule
